// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Entry layout, pointer sizing for the default depth, and destination-decode helper.
package reg_writeback_arbiter_pkg;

  localparam int DEF_DEPTH    = 4;
  localparam int DEF_MAX_WAIT = 3;
  localparam int PTR_W        = $clog2(DEF_DEPTH);

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // x0 is never a real destination, so it never contributes a pending bit.
  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    logic [31:0] mask;
    mask = 32'd1 << rd;
    if (rd == ZERO_REG) begin
      mask = 32'd0;
    end
    return mask;
  endfunction

endpackage

// File: rtl/reg_writeback_arbiter_fifo.sv
// Load-result queue: DEPTH entries, registered count, per-entry valid bits
// and destinations exposed so the top can build the pending-register mask.
module wb_fifo
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enq,
  input  wb_entry_t             wr_entry,
  input  logic                  deq,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][4:0] entry_rd
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  wb_entry_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_enq;
  logic             do_deq;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign do_enq = enq && !full;
  assign do_deq = deq && !empty;
  assign head   = mem[rd_ptr];

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr              <= wr_ptr + AW'(1);
        entry_valid[wr_ptr] <= 1'b1;
      end
      if (do_deq) begin
        rd_ptr              <= rd_ptr + AW'(1);
        entry_valid[rd_ptr] <= 1'b0;
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; entry_valid qualifies every slot.
  always_ff @(posedge clock) begin
    if (do_enq) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges single-cycle ALU results and queued load results onto the register
// file's single write port; ALU has priority, bounded by a wait counter.
module reg_writeback_arbiter
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic        regWrite,
  output logic [31:0] pending_mask
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  wb_entry_t             head;
  wb_entry_t             ld_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0][4:0] entry_rd;
  logic                  ld_enq;

  logic [WCNT_W-1:0]     wcnt;
  logic [WCNT_W-1:0]     wcnt_next;
  logic                  forced_drain;
  logic                  alu_win;
  logic                  ld_win;
  logic                  alu_write;

  assign ld_ready        = !fifo_full;
  assign ld_entry.rd     = ld_rd;
  assign ld_entry.data   = ld_data;
  // x0 loads are acknowledged but never occupy a slot.
  assign ld_enq          = ld_valid && (ld_rd != ZERO_REG);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .enq         (ld_enq),
    .wr_entry    (ld_entry),
    .deq         (ld_win),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Stall depends only on queue occupancy and the wait count, never on alu_valid.
  assign forced_drain = !fifo_empty && (wcnt == WCNT_W'(MAX_WAIT));
  assign alu_stall    = forced_drain;

  always_comb begin
    alu_win   = 1'b0;
    ld_win    = 1'b0;
    wcnt_next = wcnt;
    if (fifo_empty) begin
      alu_win   = alu_valid;
      wcnt_next = '0;
    end else if (forced_drain) begin
      ld_win    = 1'b1;
      wcnt_next = '0;
    end else if (alu_valid) begin
      alu_win   = 1'b1;
      wcnt_next = wcnt + WCNT_W'(1);
    end else begin
      ld_win    = 1'b1;
      wcnt_next = '0;
    end
  end

  assign alu_write = alu_win && (alu_rd != ZERO_REG);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt_next;
    end
  end

  // Output stage: one registered write per cycle; address/data hold when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regWrite  <= 1'b0;
      writeReg  <= ZERO_REG;
      writeData <= '0;
    end else begin
      regWrite <= alu_write || ld_win;
      if (alu_write) begin
        writeReg  <= alu_rd;
        writeData <= alu_data;
      end else if (ld_win) begin
        writeReg  <= head.rd;
        writeData <= head.data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending_mask = pending_mask | rd_onehot(entry_rd[i]);
      end
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed and randomized checks of reg_writeback_arbiter against a
// queue-based reference model of the arbitration rules.
module tb_reg_writeback_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic [31:0] pending_mask;

  reg_writeback_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clock        (clock),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_stall    (alu_stall),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .writeReg     (writeReg),
    .writeData    (writeData),
    .regWrite     (regWrite),
    .pending_mask (pending_mask)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  ent_t        q[$];
  int          w = 0;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_wr = '0;
  logic [31:0] exp_wd = '0;
  logic        last_alu_acc = 1'b1;
  logic        last_ld_acc = 1'b1;
  logic        log_en = 1'b0;
  logic        saw_full = 1'b0;
  logic [4:0]  wr_log[$];
  int          accepted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m |= (32'd1 << q[i].rd);
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    w      = 0;
    exp_we = 1'b0;
    exp_wr = '0;
    exp_wd = '0;
  endtask

  // Called #1 after a rising edge with inputs already driven; ends #1 after the next edge.
  task automatic cycle();
    logic alu_take, ld_take, ready_pre;
    ent_t e;
    #1;
    ready_pre = (q.size() < DEPTH);
    chk("ld_ready", ld_ready, ready_pre);
    chk("alu_stall", alu_stall, (q.size() > 0) && (w == MAX_WAIT));
    chk("pending_mask", pending_mask, model_mask());
    if (!ld_ready) saw_full = 1'b1;
    alu_take = 1'b0;
    ld_take  = 1'b0;
    if (q.size() == 0) begin
      alu_take = alu_valid; w = 0;
    end else if (w == MAX_WAIT) begin
      ld_take = 1'b1; w = 0;
    end else if (alu_valid) begin
      alu_take = 1'b1; w++;
    end else begin
      ld_take = 1'b1; w = 0;
    end
    exp_we = 1'b0;
    if (alu_take && alu_rd != 5'd0) begin
      exp_we = 1'b1; exp_wr = alu_rd; exp_wd = alu_data;
    end else if (ld_take) begin
      e = q.pop_front();
      exp_we = 1'b1; exp_wr = e.rd; exp_wd = e.data;
    end
    if (ld_valid && ready_pre && ld_rd != 5'd0) q.push_back({ld_rd, ld_data});
    last_alu_acc = alu_take;
    last_ld_acc  = ld_valid && ready_pre;
    @(posedge clock);
    #1;
    chk("regWrite", regWrite, exp_we);
    chk("writeReg", writeReg, exp_wr);
    chk("writeData", writeData, exp_wd);
    if (log_en && regWrite) wr_log.push_back(writeReg);
  endtask

  initial begin
    reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_regWrite", regWrite, 1'b0);
    chk("rst_writeReg", writeReg, 5'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_alu_stall", alu_stall, 1'b0);
    chk("rst_mask", pending_mask, 32'd0);

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cycle();
    chk("alu_we", regWrite, 1'b1);
    chk("alu_rd5", writeReg, 5'd5);
    chk("alu_data", writeData, 32'hDEADBEEF);
    alu_rd = 0; alu_data = 32'h0BAD0BAD;
    cycle();
    chk("alu_x0_we", regWrite, 1'b0);
    alu_valid = 0;
    cycle();

    // Load only
    ld_valid = 1; ld_rd = 7; ld_data = 32'h12345678;
    cycle();
    ld_valid = 0;
    chk("ld_mask_set", pending_mask, 32'h80);
    chk("ld_no_write_yet", regWrite, 1'b0);
    cycle();
    chk("ld_we", regWrite, 1'b1);
    chk("ld_rd7", writeReg, 5'd7);
    chk("ld_data", writeData, 32'h12345678);
    chk("ld_mask_clr", pending_mask, 32'd0);

    // Starvation bound
    alu_valid = 1; alu_rd = 1; alu_data = 32'h100;
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    cycle();
    ld_valid = 0;
    for (int k = 0; k < 3; k++) begin
      alu_rd = 5'(k + 2); alu_data = 32'h200 + k;
      cycle();
      chk("starve_alu_wr", writeReg, 5'(k + 2));
    end
    alu_rd = 20; alu_data = 32'h300;
    chk("starve_stall", alu_stall, 1'b1);
    cycle();
    chk("starve_drain_rd", writeReg, 5'd9);
    chk("starve_resume_stall", alu_stall, 1'b0);
    cycle();
    chk("starve_resume_rd", writeReg, 5'd20);

    // Full FIFO with ALU continuously valid
    alu_rd = 3; alu_data = 32'h333;
    log_en = 1; wr_log.delete(); saw_full = 0; accepted = 0;
    ld_valid = 1; ld_rd = 10; ld_data = 32'hA0;
    for (int c = 0; c < 40 && accepted < 5; c++) begin
      cycle();
      if (last_ld_acc) begin
        accepted++;
        ld_rd = 5'(10 + accepted); ld_data = 32'hA0 + accepted;
      end
    end
    ld_valid = 0;
    chk("full_accepted", accepted, 5);
    chk("full_seen", saw_full, 1'b1);
    for (int c = 0; c < 12; c++) cycle();
    alu_valid = 0;
    for (int c = 0; c < 6; c++) cycle();
    log_en = 0;
    begin
      logic [4:0] ld_order[$];
      foreach (wr_log[i]) if (wr_log[i] >= 5'd10) ld_order.push_back(wr_log[i]);
      chk("full_count", ld_order.size(), 5);
      for (int i = 0; i < ld_order.size() && i < 5; i++) chk("full_order", ld_order[i], 10 + i);
    end

    // x0 load is swallowed
    ld_valid = 1; ld_rd = 0; ld_data = 32'hFFFF;
    chk("x0_ready", ld_ready, 1'b1);
    cycle();
    ld_valid = 0;
    chk("x0_mask", pending_mask, 32'd0);
    cycle();
    chk("x0_no_write", regWrite, 1'b0);

    // Reset mid-stream with three loads queued
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1; ld_rd = 5'(21 + k); ld_data = 32'hC0 + k;
      cycle();
    end
    ld_valid = 0;
    chk("pre_rst_mask", pending_mask, 32'h00E00000);
    #2 reset = 1'b1;
    #1;
    chk("midrst_we", regWrite, 1'b0);
    chk("midrst_mask", pending_mask, 32'd0);
    chk("midrst_ready", ld_ready, 1'b1);
    chk("midrst_stall", alu_stall, 1'b0);
    model_reset();
    alu_valid = 0;
    @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("post_rst_idle", regWrite, 1'b0);
    end

    // Randomized traffic with upstream hold semantics
    last_alu_acc = 1; last_ld_acc = 1;
    for (int c = 0; c < 400; c++) begin
      if (!(alu_valid && !last_alu_acc)) begin
        alu_valid = ($urandom_range(0, 99) < 70);
        alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!(ld_valid && !last_ld_acc)) begin
        ld_valid = ($urandom_range(0, 99) < 45);
        ld_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        ld_data  = $urandom;
      end
      cycle();
    end
    alu_valid = 0; ld_valid = 0;
    for (int c = 0; c < 10; c++) cycle();
    chk("drain_empty_mask", pending_mask, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
